// File: rtl/store_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : store_write_buffer_if
// Description : Core-side store/load signals and memory-side write channel
//               of the store write buffer, bundled for connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_write_buffer_if;
    // Core side
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    // Memory side
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic        empty;

    // The buffer itself
    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_wready,
        output cpu_rdata, stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, empty
    );

    // The environment around the buffer (core plus memory)
    modport master (
        output cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_wready,
        input  cpu_rdata, stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, empty
    );
endinterface
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_write_buffer
// Description : Posted-write FIFO between the core data port and data memory.
//               Stores are accepted in one cycle and drained in order over a
//               valid/ready channel; loads forward the newest buffered store.
// Revision    : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    store_write_buffer_if.slave bus
);

    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    // Entry storage: contents are don't-care until written, so no reset
    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_age_idx [DEPTH];
    logic [DEPTH-1:0] w_age_hit;
    logic [31:0]      w_fwd_data;

    // A store on a full buffer is refused even if the head drains this cycle,
    // so stall never depends on mem_wready.
    assign w_full  = (r_count == c_depth);
    assign w_push  = bus.cpu_we & ~w_full;
    assign w_pop   = bus.mem_wvalid & bus.mem_wready;

    assign bus.stall      = bus.cpu_we & w_full;
    assign bus.empty      = (r_count == '0);
    assign bus.mem_wvalid = (r_count != '0);
    assign bus.mem_waddr  = r_addr[r_rd_ptr];
    assign bus.mem_wdata  = r_data[r_rd_ptr];
    assign bus.mem_raddr  = bus.cpu_addr;
    assign bus.cpu_rdata  = w_fwd_data;

    // Capture an accepted store into the tail slot
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= bus.cpu_addr;
            r_data[r_wr_ptr] <= bus.cpu_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all pending stores
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Slots are examined by age (0 = head) so priority survives pointer wrap.
    // The head still counts as valid on the cycle it is popped.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign w_age_idx[g] = r_rd_ptr + PTR_W'(g);
        assign w_age_hit[g] = ((PTR_W+1)'(g) < r_count) &&
                              (r_addr[w_age_idx[g]][31:2] == bus.cpu_addr[31:2]);
    end

    // Newest matching entry wins; otherwise pass memory read data through
    always_comb begin
        w_fwd_data = bus.mem_rdata;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_age_hit[i]) w_fwd_data = r_data[w_age_idx[i]];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_write_buffer
// Description : Directed scoreboard bench for store_write_buffer. Accepted
//               stores are queued as expected writes; a monitor pops and
//               compares every write-channel handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

    logic clk;
    logic reset;
    logic mon_en;
    int   n_cmp;
    int   n_err;
    logic [63:0] exp_q [$];

    store_write_buffer_if bus ();

    store_write_buffer #(
        .DEPTH(4),
        .PTR_W(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge; leaves time at edge+3
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic wr, input logic [31:0] rd, input logic acc);
        @(posedge clk);
        #1;
        bus.cpu_we     = we;
        bus.cpu_addr   = a;
        bus.cpu_wdata  = d;
        bus.mem_wready = wr;
        bus.mem_rdata  = rd;
        if (acc) exp_q.push_back({a, d});
        #2;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected store
    always @(negedge clk) begin
        if (mon_en && !reset && bus.mem_wvalid && bus.mem_wready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL drain: got write %h=%h expected no write", bus.mem_waddr, bus.mem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.mem_waddr, bus.mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL drain: got %h=%h expected %h=%h",
                             bus.mem_waddr, bus.mem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        mon_en = 1'b0;
        reset = 1'b1;
        bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_wready = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Reset state
        step(0, 32'h0, 32'h0, 0, 32'h0, 0);
        check("reset_wvalid", 32'(bus.mem_wvalid), 32'd0);
        check("reset_empty",  32'(bus.empty),      32'd1);
        check("reset_stall",  32'(bus.stall),      32'd0);

        // Single store drains next cycle
        step(1, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1);
        check("single_stall", 32'(bus.stall), 32'd0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 0);
        check("single_wvalid", 32'(bus.mem_wvalid), 32'd1);
        check("single_waddr",  bus.mem_waddr, 32'h10);
        check("single_wdata",  bus.mem_wdata, 32'hDEADBEEF);
        step(0, 32'h0, 32'h0, 1, 32'h0, 0);
        check("single_empty", 32'(bus.empty), 32'd1);

        // Fill to DEPTH with the channel blocked, then overflow attempts
        for (int i = 0; i < 4; i++) begin
            step(1, 32'(4 * i), 32'h100 + 32'(i), 0, 32'h0, 1);
            check("fill_stall", 32'(bus.stall), 32'd0);
        end
        step(1, 32'h10, 32'h55, 0, 32'h0, 0);
        check("full_stall", 32'(bus.stall), 32'd1);
        check("full_waddr", bus.mem_waddr, 32'h0);
        step(0, 32'h0, 32'h0, 0, 32'h0, 0);
        check("hold_waddr", bus.mem_waddr, 32'h0);
        check("hold_wdata", bus.mem_wdata, 32'h100);
        // Full with a pop in the same cycle still refuses the store
        step(1, 32'h10, 32'h55, 1, 32'h0, 0);
        check("full_pop_stall", 32'(bus.stall), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step(0, 32'h0, 32'h0, 1, 32'h0, 0);
            check("drain_waddr", bus.mem_waddr, 32'(4 * i));
        end
        step(0, 32'h0, 32'h0, 0, 32'h0, 0);
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Newest-match forwarding
        step(1, 32'h20, 32'h1, 0, 32'h0, 1);
        step(1, 32'h20, 32'h2, 0, 32'h0, 1);
        step(0, 32'h20, 32'h0, 0, 32'h99, 0);
        check("fwd_newest", bus.cpu_rdata, 32'h2);
        step(0, 32'h24, 32'h0, 0, 32'h99, 0);
        check("fwd_miss",  bus.cpu_rdata, 32'h99);
        check("raddr",     bus.mem_raddr, 32'h24);
        step(0, 32'h0, 32'h0, 1, 32'h0, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 0);
        step(0, 32'h0, 32'h0, 0, 32'h0, 0);
        check("fwd_empty", 32'(bus.empty), 32'd1);

        // Steady stream: one store and one drain per cycle, pointers wrap
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i), 1, 32'h0, 1);
            check("stream_stall", 32'(bus.stall), 32'd0);
            if (i > 0) begin
                check("stream_wvalid", 32'(bus.mem_wvalid), 32'd1);
                check("stream_waddr",  bus.mem_waddr, 32'h40 + 32'(4 * (i - 1)));
            end
        end
        step(0, 32'h0, 32'h0, 1, 32'h0, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 0);
        check("stream_empty", 32'(bus.empty), 32'd1);

        // Reset mid-flight discards pending stores
        step(1, 32'h50, 32'h11, 0, 32'h0, 1);
        step(1, 32'h54, 32'h22, 0, 32'h0, 1);
        step(1, 32'h58, 32'h33, 0, 32'h0, 1);
        step(0, 32'h54, 32'h0, 0, 32'h77, 0);
        check("pre_reset_fwd", bus.cpu_rdata, 32'h22);
        reset = 1'b1;
        exp_q.delete();
        step(0, 32'h54, 32'h0, 0, 32'h77, 0);
        reset = 1'b0;
        check("mid_reset_wvalid", 32'(bus.mem_wvalid), 32'd0);
        check("mid_reset_empty",  32'(bus.empty),      32'd1);
        check("mid_reset_fwd",    bus.cpu_rdata,       32'h77);
        step(0, 32'h0, 32'h0, 1, 32'h0, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 0);

        // Head still forwards on the cycle it pops
        step(1, 32'h30, 32'h5, 0, 32'h0, 1);
        step(0, 32'h30, 32'h0, 1, 32'h0, 0);
        check("pop_fwd", bus.cpu_rdata, 32'h5);
        step(0, 32'h30, 32'h0, 1, 32'h0, 0);
        check("pop_fwd_after", bus.cpu_rdata, 32'h0);
        check("pop_empty",     32'(bus.empty), 32'd1);

        step(0, 32'h0, 32'h0, 0, 32'h0, 0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
